// File: rtl/serial_subtractor_32.sv
// Digit-serial subtractor: a - b - borrow_i, DIGIT bits per cycle, LSB first.
// Valid/ready request in, valid/ready result out; one operation in flight.
module serial_subtractor_32 #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             borrow_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_o,
  output logic             overflow_o
);

  localparam int K  = WIDTH / DIGIT;
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0] LAST = CW'(K - 1);

  generate
    if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
      $error("serial_subtractor_32: WIDTH must be a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d;
  logic             init_q;
  logic [DIGIT:0]   slice;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      init_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      init_q   <= 1'b1;
    end
  end

  // Low slice of the shifting operands; the top bit is that slice's borrow-out.
  assign slice = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]}
               - {{DIGIT{1'b0}}, borrow_q};

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ready_o  = init_q && (state_q == IDLE);
    valid_o  = (state_q == DONE);

    case (state_q)
      IDLE: begin
        if (valid_i && ready_o) begin
          a_d      = a_i;
          b_d      = b_i;
          borrow_d = borrow_i;
          a_msb_d  = a_i[WIDTH-1];
          b_msb_d  = b_i[WIDTH-1];
          res_d    = '0;
          cnt_d    = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        a_d      = a_q >> DIGIT;
        b_d      = b_q >> DIGIT;
        res_d    = res_q >> DIGIT;
        res_d[WIDTH-1 -: DIGIT] = slice[DIGIT-1:0];
        borrow_d = slice[DIGIT];
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign diff_o     = valid_o ? res_q : '0;
  assign borrow_o   = valid_o & borrow_q;
  assign overflow_o = valid_o & (a_msb_q != b_msb_q) & (res_q[WIDTH-1] != a_msb_q);

endmodule

// File: tb/tb_serial_subtractor_32.sv
// Randomised and directed bench for serial_subtractor_32 against a
// cycle-level arithmetic reference model.
module tb_serial_subtractor_32;

  localparam int W = 32;
  localparam int K = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         valid_i = 1'b0;
  logic         ready_o;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         borrow_i = 1'b0;
  logic         valid_o;
  logic         ready_i = 1'b0;
  logic [W-1:0] diff_o;
  logic         borrow_o;
  logic         overflow_o;

  int checks = 0;
  int errors = 0;

  serial_subtractor_32 #(.WIDTH(W), .DIGIT(4)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .a_i       (a_i),
    .b_i       (b_i),
    .borrow_i  (borrow_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .diff_o    (diff_o),
    .borrow_o  (borrow_o),
    .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 busy (counting down), 2 result held.
  int          m_phase = 0;
  int          m_left  = 0;
  bit          m_init  = 1'b0;
  logic [W:0]  m_res   = '0;
  logic        m_ovf   = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_left  <= 0;
      m_init  <= 1'b0;
    end else begin
      case (m_phase)
        0: if (m_init && valid_i) begin
          m_res   <= {1'b0, a_i} - {1'b0, b_i} - {{W{1'b0}}, borrow_i};
          m_ovf   <= (a_i[W-1] != b_i[W-1]) &&
                     ((a_i - b_i - {{(W-1){1'b0}}, borrow_i}) >> (W-1)) != {{(W-1){1'b0}}, a_i[W-1]};
          m_left  <= K;
          m_phase <= 1;
        end
        1: begin
          m_left <= m_left - 1;
          if (m_left == 1) m_phase <= 2;
        end
        default: if (ready_i) m_phase <= 0;
      endcase
      m_init <= 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("ready_o", W'(ready_o), W'(m_init && m_phase == 0));
    chk("valid_o", W'(valid_o), W'(m_phase == 2));
    chk("diff_o", diff_o, (m_phase == 2) ? m_res[W-1:0] : '0);
    chk("borrow_o", W'(borrow_o), W'((m_phase == 2) && m_res[W]));
    chk("overflow_o", W'(overflow_o), W'((m_phase == 2) && m_ovf));
  end

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic br,
                       input int hold, output logic [W-1:0] d, output logic bo,
                       output logic ov);
    int n;
    logic [W:0] ref_full;
    d = '0; bo = 1'b0; ov = 1'b0;
    n = 0;
    while (!ready_o && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!ready_o) begin
      chk("ready_timeout", 0, 1);
      return;
    end
    a_i = a; b_i = b; borrow_i = br; valid_i = 1'b1; ready_i = 1'b0;
    @(posedge clk); #1;
    valid_i = 1'b0;
    n = 0;
    while (!valid_o && n < 50) begin
      a_i = $urandom; b_i = $urandom; borrow_i = 1'($urandom);
      ready_i = 1'($urandom);
      @(posedge clk); #1; n++;
    end
    if (!valid_o) begin
      chk("valid_timeout", 0, 1);
      return;
    end
    chk("latency", W'(n), W'(K));
    chk("ready_o_in_done", W'(ready_o), 0);
    d = diff_o; bo = borrow_o; ov = overflow_o;
    ref_full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, br};
    chk("diff_vs_arith", d, ref_full[W-1:0]);
    chk("borrow_vs_arith", W'(bo), W'(ref_full[W]));
    for (int i = 0; i < hold; i++) begin
      ready_i = 1'b0; valid_i = 1'b1; a_i = $urandom; b_i = $urandom;
      @(posedge clk); #1;
      chk("hold_valid", W'(valid_o), 1);
      chk("hold_ready", W'(ready_o), 0);
      chk("hold_diff", diff_o, d);
      chk("hold_borrow", W'(borrow_o), W'(bo));
      chk("hold_ovf", W'(overflow_o), W'(ov));
    end
    valid_i = 1'b0; ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
    chk("ready_after_consume", W'(ready_o), 1);
    chk("valid_after_consume", W'(valid_o), 0);
    $display("op a=%h b=%h bin=%0d -> diff=%h bout=%0d ovf=%0d lat=%0d hold=%0d",
             a, b, br, d, bo, ov, n, hold);
  endtask

  initial begin
    logic [W-1:0] d;
    logic bo, ov;
    bit saw_valid;
    #1;
    chk("reset_ready", W'(ready_o), 0);
    chk("reset_valid", W'(valid_o), 0);
    chk("reset_diff", diff_o, 0);
    #21 rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(32'd10, 32'd3, 1'b0, 0, d, bo, ov);
    chk("t1_diff", d, 32'd7);
    chk("t1_borrow", W'(bo), 0);
    chk("t1_ovf", W'(ov), 0);

    do_op(32'd3, 32'd10, 1'b0, 0, d, bo, ov);
    chk("t2_diff", d, 32'hFFFF_FFF9);
    chk("t2_borrow", W'(bo), 1);
    chk("t2_ovf", W'(ov), 0);

    do_op(32'd0, 32'd0, 1'b1, 0, d, bo, ov);
    chk("t3_diff", d, 32'hFFFF_FFFF);
    chk("t3_borrow", W'(bo), 1);
    chk("t3_ovf", W'(ov), 0);

    do_op(32'h8000_0000, 32'd1, 1'b0, 5, d, bo, ov);
    chk("t4_diff", d, 32'h7FFF_FFFF);
    chk("t4_borrow", W'(bo), 0);
    chk("t4_ovf", W'(ov), 1);

    // Abort in the third CALC cycle.
    a_i = 32'h1234_5678; b_i = 32'h0000_0001; borrow_i = 1'b0; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("abort_ready", W'(ready_o), 0);
    chk("abort_valid", W'(valid_o), 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (valid_o) saw_valid = 1'b1;
    end
    chk("abort_no_result", W'(saw_valid), 0);
    $display("op reset in CALC cycle 3, no result presented=%0d", !saw_valid);

    do_op(32'd5, 32'd5, 1'b0, 0, d, bo, ov);
    chk("t5_diff", d, 32'd0);
    chk("t5_borrow", W'(bo), 0);

    for (int i = 0; i < 100; i++) begin
      logic [W-1:0] ra, rb;
      ra = $urandom; rb = $urandom;
      if (i % 10 == 0) rb = ra;
      if (i % 17 == 0) ra = 32'h8000_0000;
      do_op(ra, rb, 1'($urandom), (i % 13 == 0) ? 2 : 0, d, bo, ov);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
